int_src: RTL and testbench
==========================

INT_SRC -- requirements
Module: int_src

Parameters
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive stable cycles required before a synchronized button level is accepted; legal range 1..255.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port btn, input, 3 bits: raw asynchronous interrupt sources; bit i is channel i+1.
REQ-005 The block SHALL have port ack, input, 1 bit: arbiter accepted a request this cycle.
REQ-006 The block SHALL have port ack_id, input, 2 bits: channel code of ack (1..3; 0 = none).
REQ-007 The block SHALL have port done, input, 1 bit: service routine finished (eret) this cycle.
REQ-008 The block SHALL have port done_id, input, 2 bits: channel code of done (1..3; 0 = none).
REQ-009 The block SHALL have port ir, output, 3 bits: registered level request per channel, toward the arbiter.
REQ-010 The block SHALL have port pending, output, 3 bits: one queued event per channel.
REQ-011 The block SHALL have port busy, output, 3 bits: channel in SERVICE.
REQ-012 The block SHALL have port drop_cnt, output, 8 bits: saturating count of lost events, all channels.

Function
REQ-013 Each btn bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Per channel, an 8-bit counter SHALL increment while s2 differs from debounced level deb, and clear to 0 while they are equal.
REQ-015 When s2 differs from deb and the counter equals DEBOUNCE-1, deb SHALL take s2 and the counter SHALL clear on that edge.
REQ-016 A deb 0->1 update SHALL be an event; 1->0 updates SHALL produce no event.
REQ-017 Per channel, a state machine SHALL have states IDLE, REQ and SERVICE; ir[i] = (state==REQ) and busy[i] = (state==SERVICE), both from registers.
REQ-018 In IDLE, an event or pending[i]=1 SHALL move the channel to REQ on the same edge; pending[i] clears if it was used.
REQ-019 In REQ, ack with ack_id==i+1 SHALL move the channel to SERVICE; otherwise it stays in REQ.
REQ-020 In SERVICE, done with done_id==i+1 SHALL move the channel to IDLE; otherwise it stays in SERVICE.
REQ-021 An event in REQ or SERVICE with pending[i]=0 SHALL set pending[i], including when it coincides with ack or done.
REQ-022 An event with pending[i]=1 in REQ or SERVICE SHALL increment drop_cnt, saturating at 255.
REQ-023 Simultaneous drops on several channels in one cycle SHALL add their count to drop_cnt, still saturating at 255.
REQ-024 ack or done whose id does not match a channel in the required state, or whose id is 0, SHALL be ignored with no state change.
REQ-025 After SERVICE->IDLE with pending[i]=1, the channel SHALL re-enter REQ on the next edge, so ir[i] is low for exactly one cycle (a fresh rising edge for the arbiter).
REQ-026 Channels SHALL be fully independent; there is no priority inside this block.
REQ-027 Latency SHALL be: with btn[i] rising and held, ir[i] is high after the (DEBOUNCE+2)th rising clk edge (6 edges for DEBOUNCE=4).

Reset
REQ-028 With clr_n=0 at an edge, the block SHALL set all states to IDLE and clear s1, s2, deb, the counters, pending and drop_cnt; ir, pending and busy read 000 and drop_cnt reads 0.
REQ-029 A reset asserted mid-operation (any state) SHALL take effect on that edge; a btn held high through reset SHALL re-qualify from the start and produce a new event after release.

Verification
REQ-030 The bench SHALL check: DEBOUNCE=4, btn=001 held from reset release -> ir=001 after edge 6, ir=000 at edge 5; ack=1, ack_id=1 for 1 cycle -> ir=000, busy=001.
REQ-031 The bench SHALL check: btn[0] glitch high for 3 cycles then low -> ir stays 000 and the counter returns to 0.
REQ-032 The bench SHALL check: in SERVICE a second event arrives -> pending=001; done=1, done_id=1 -> IDLE, then ir=001 on the next edge, pending=000.
REQ-033 The bench SHALL check: in SERVICE with pending=001, a third event arrives -> drop_cnt=1; after 300 such drops -> drop_cnt=255.
REQ-034 The bench SHALL check: ch1 and ch3 requested together, then ack_id=2 -> no change; ack_id=3 -> busy=100 and ir=001.
REQ-035 The bench SHALL check: clr_n=0 for one edge while busy=010 and pending=010 -> all outputs 0 on that edge.

Source files
------------

// File: rtl/int_src.sv
// Three-channel interrupt source: synchronizes and debounces buttons, then
// runs a per-channel IDLE/REQ/SERVICE handshake with a one-deep event queue.
module int_src #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [2:0] btn,
    input  logic       ack,
    input  logic [1:0] ack_id,
    input  logic       done,
    input  logic [1:0] done_id,
    output logic [2:0] ir,
    output logic [2:0] pending,
    output logic [2:0] busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);

    logic [2:0]      s1_q, s2_q;
    logic [2:0]      deb_q, deb_d;
    logic [2:0][7:0] cnt_q, cnt_d;
    logic [2:0]      evt;
    logic [2:0]      pend_q, pend_d;
    logic [2:0]      drop;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [9:0]      drop_sum;
    state_e          state_q [3];
    state_e          state_d [3];

    // Only a debounced rising level counts as an event.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        evt   = '0;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
                evt[i]   = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        drop   = '0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (pend_q[i]) begin
                        state_d[i] = REQ;
                        pend_d[i]  = evt[i];
                    end else if (evt[i]) begin
                        state_d[i] = REQ;
                    end
                end
                REQ: begin
                    if (ack && ack_id == 2'(i + 1)) state_d[i] = SERVICE;
                end
                SERVICE: begin
                    if (done && done_id == 2'(i + 1)) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
            // Events arriving while the channel is occupied queue once, then drop.
            if (evt[i] && state_q[i] != IDLE) begin
                if (pend_q[i]) drop[i] = 1'b1;
                else           pend_d[i] = 1'b1;
            end
        end
        drop_sum   = {2'b00, drop_cnt_q} + {9'd0, drop[0]} + {9'd0, drop[1]} + {9'd0, drop[2]};
        drop_cnt_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < 3; i++) state_q[i] <= IDLE;
        end else begin
            s1_q       <= btn;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < 3; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        ir   = '0;
        busy = '0;
        for (int i = 0; i < 3; i++) begin
            ir[i]   = (state_q[i] == REQ);
            busy[i] = (state_q[i] == SERVICE);
        end
    end

    assign pending  = pend_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_int_src.sv
// Directed bench for int_src: expectations are queued with each stimulus step
// and popped for comparison once the DUT has clocked.
module tb_int_src;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [2:0] btn;
    logic       ack;
    logic [1:0] ack_id;
    logic       done;
    logic [1:0] done_id;
    logic [2:0] ir;
    logic [2:0] pending;
    logic [2:0] busy;
    logic [7:0] drop_cnt;

    int passCnt  = 0;
    int totalCnt = 0;

    string       tagQ[$];
    logic [16:0] expQ[$];

    int_src #(.DEBOUNCE(4)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .btn      (btn),
        .ack      (ack),
        .ack_id   (ack_id),
        .done     (done),
        .done_id  (done_id),
        .ir       (ir),
        .pending  (pending),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkOutput();
        string       tag;
        logic [16:0] e;
        tag = tagQ.pop_front();
        e   = expQ.pop_front();
        cmp({tag, ".ir"},       {5'd0, ir},      {5'd0, e[16:14]});
        cmp({tag, ".pending"},  {5'd0, pending}, {5'd0, e[13:11]});
        cmp({tag, ".busy"},     {5'd0, busy},    {5'd0, e[10:8]});
        cmp({tag, ".drop_cnt"}, drop_cnt,        e[7:0]);
    endtask

    task automatic applyStimulus(input string tag, input int n, input logic [2:0] eIr,
                                 input logic [2:0] ePend, input logic [2:0] eBusy,
                                 input logic [7:0] eDrop);
        tagQ.push_back(tag);
        expQ.push_back({eIr, ePend, eBusy, eDrop});
        cycles(n);
        checkOutput();
    endtask

    task automatic makeEvent(input logic [2:0] mask);
        btn = btn & ~mask;
        cycles(8);
        btn = btn | mask;
        cycles(6);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr_n = 1'b0; btn = '0; ack = 1'b0; ack_id = '0; done = 1'b0; done_id = '0;
        applyStimulus("reset", 1, 3'b000, 3'b000, 3'b000, 8'd0);

        // Short glitch must never qualify.
        clr_n = 1'b1; btn = 3'b001;
        applyStimulus("glitch_hi", 3, 3'b000, 3'b000, 3'b000, 8'd0);
        btn = 3'b000;
        applyStimulus("glitch_lo", 5, 3'b000, 3'b000, 3'b000, 8'd0);
        cmp("glitch_cnt", dut.cnt_q[0], 8'd0);

        // Latency from reset release with button held.
        clr_n = 1'b0; btn = 3'b001;
        applyStimulus("rst_btn", 1, 3'b000, 3'b000, 3'b000, 8'd0);
        clr_n = 1'b1;
        applyStimulus("lat_e5", 5, 3'b000, 3'b000, 3'b000, 8'd0);
        applyStimulus("lat_e6", 1, 3'b001, 3'b000, 3'b000, 8'd0);
        ack = 1'b1; ack_id = 2'd1;
        applyStimulus("ack1", 1, 3'b000, 3'b000, 3'b001, 8'd0);
        ack = 1'b0; ack_id = 2'd0;

        // Second event during service queues; done re-requests next edge.
        btn = 3'b000;
        applyStimulus("deb_fall", 8, 3'b000, 3'b000, 3'b001, 8'd0);
        btn = 3'b001;
        applyStimulus("ev2_e5", 5, 3'b000, 3'b000, 3'b001, 8'd0);
        applyStimulus("ev2_pend", 1, 3'b000, 3'b001, 3'b001, 8'd0);
        done = 1'b1; done_id = 2'd1;
        applyStimulus("done1", 1, 3'b000, 3'b001, 3'b000, 8'd0);
        done = 1'b0; done_id = 2'd0;
        applyStimulus("rereq", 1, 3'b001, 3'b000, 3'b000, 8'd0);

        // Drops and saturation.
        ack = 1'b1; ack_id = 2'd1;
        applyStimulus("ack1b", 1, 3'b000, 3'b000, 3'b001, 8'd0);
        ack = 1'b0; ack_id = 2'd0;
        makeEvent(3'b001);
        applyStimulus("ev_pend", 0, 3'b000, 3'b001, 3'b001, 8'd0);
        makeEvent(3'b001);
        applyStimulus("drop1", 0, 3'b000, 3'b001, 3'b001, 8'd1);
        for (int k = 2; k <= 254; k++) makeEvent(3'b001);
        applyStimulus("drop254", 0, 3'b000, 3'b001, 3'b001, 8'd254);
        for (int k = 255; k <= 300; k++) makeEvent(3'b001);
        applyStimulus("drop_sat", 0, 3'b000, 3'b001, 3'b001, 8'd255);

        clr_n = 1'b0; btn = 3'b000;
        applyStimulus("rst2", 1, 3'b000, 3'b000, 3'b000, 8'd0);

        // Two channels, mismatched acks ignored.
        clr_n = 1'b1; btn = 3'b101;
        applyStimulus("pair_e6", 6, 3'b101, 3'b000, 3'b000, 8'd0);
        ack = 1'b1; ack_id = 2'd2;
        applyStimulus("ack_id2", 1, 3'b101, 3'b000, 3'b000, 8'd0);
        ack_id = 2'd0;
        applyStimulus("ack_id0", 1, 3'b101, 3'b000, 3'b000, 8'd0);
        ack_id = 2'd3;
        applyStimulus("ack_id3", 1, 3'b001, 3'b000, 3'b100, 8'd0);
        ack = 1'b0; ack_id = 2'd0; done = 1'b1; done_id = 2'd1;
        applyStimulus("done_wrong", 1, 3'b001, 3'b000, 3'b100, 8'd0);
        done = 1'b0; done_id = 2'd0; ack = 1'b1; ack_id = 2'd1;
        applyStimulus("ack_ch1", 1, 3'b000, 3'b000, 3'b101, 8'd0);
        ack = 1'b0; ack_id = 2'd0;
        makeEvent(3'b101);
        applyStimulus("pend101", 0, 3'b000, 3'b101, 3'b101, 8'd0);
        makeEvent(3'b101);
        applyStimulus("drop2", 0, 3'b000, 3'b101, 3'b101, 8'd2);

        // Mid-operation reset, then re-qualification of a held button.
        clr_n = 1'b0; btn = 3'b010;
        applyStimulus("rst3", 1, 3'b000, 3'b000, 3'b000, 8'd0);
        clr_n = 1'b1;
        applyStimulus("ch2_e6", 6, 3'b010, 3'b000, 3'b000, 8'd0);
        ack = 1'b1; ack_id = 2'd2;
        applyStimulus("ack2", 1, 3'b000, 3'b000, 3'b010, 8'd0);
        ack = 1'b0; ack_id = 2'd0;
        makeEvent(3'b010);
        applyStimulus("pend010", 0, 3'b000, 3'b010, 3'b010, 8'd0);
        clr_n = 1'b0;
        applyStimulus("rst_mid", 1, 3'b000, 3'b000, 3'b000, 8'd0);
        clr_n = 1'b1;
        applyStimulus("requal_e5", 5, 3'b000, 3'b000, 3'b000, 8'd0);
        applyStimulus("requal_e6", 1, 3'b010, 3'b000, 3'b000, 8'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
